// File: rtl/alarm_input_pkg.sv
// Shared constants and types for the alarm-clock input conditioning path.
// Cycle counts assume the 50 MHz system clock of the CPU system.
package alarm_input_pkg;

    localparam int DB_CYCLES_50MHZ     = 500000;    // 10 ms
    localparam int HOLD_CYCLES_50MHZ   = 25000000;  // 500 ms
    localparam int REPEAT_CYCLES_50MHZ = 10000000;  // 200 ms

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } btn_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-FF synchroniser followed by a counter debouncer.
// stable_next is the value stable will take at the coming edge, so callers can act on a change in the same cycle it lands.
module debounce_channel
    import alarm_input_pkg::*;
#(
    parameter int   DB_CYCLES = DB_CYCLES_50MHZ,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic stable_next
);

    localparam int             CW       = $clog2(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Any cycle where sync agrees with stable restarts the count, so short glitches die here.
    always_comb begin
        cnt_next    = '0;
        stable_next = stable;
        if (sync != stable) begin
            if (cnt == CNT_LAST) begin
                stable_next = sync;
            end else begin
                cnt_next = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable <= RESET_VAL;
            cnt    <= '0;
        end else begin
            stable <= stable_next;
            cnt    <= cnt_next;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Debounces the board switches and edit buttons for the CPU PIOs and turns
// button presses into single-cycle pulses with optional hold-to-repeat.
module input_conditioner
    import alarm_input_pkg::*;
#(
    parameter int N_SW           = 3,
    parameter int N_BTN          = 2,
    parameter int DB_CYCLES      = DB_CYCLES_50MHZ,
    parameter int HOLD_CYCLES    = HOLD_CYCLES_50MHZ,
    parameter int REPEAT_CYCLES  = REPEAT_CYCLES_50MHZ,
    parameter int REPEAT_EN      = 1,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SW-1:0]  sw_raw,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_SW-1:0]  sw_states,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_repeating
);

    localparam logic          BTN_IDLE_RAW = (BTN_ACTIVE_LOW != 0);
    localparam int            TW           = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES));
    localparam logic [TW-1:0] HOLD_LAST    = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REPEAT_LAST  = TW'(REPEAT_CYCLES - 1);

    logic [N_SW-1:0] unused_sw_next;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_channel #(
            .DB_CYCLES (DB_CYCLES),
            .RESET_VAL (1'b0)
        ) u_db (
            .clk         (clk),
            .reset       (reset),
            .raw         (sw_raw[i]),
            .stable      (sw_states[i]),
            .stable_next (unused_sw_next[i])
        );
    end

    for (genvar b = 0; b < N_BTN; b++) begin : g_btn
        logic          raw_stable;
        logic          raw_stable_next;
        logic          pressed_next;
        btn_state_t    state;
        btn_state_t    state_next;
        logic [TW-1:0] timer;
        logic [TW-1:0] timer_next;
        logic          pulse_q;
        logic          pulse_next;

        // Debounce runs in the raw polarity so the synchroniser can reset to the released level.
        debounce_channel #(
            .DB_CYCLES (DB_CYCLES),
            .RESET_VAL (BTN_IDLE_RAW)
        ) u_db (
            .clk         (clk),
            .reset       (reset),
            .raw         (btn_raw[b]),
            .stable      (raw_stable),
            .stable_next (raw_stable_next)
        );

        assign pressed_next     = raw_stable_next ^ BTN_IDLE_RAW;
        assign btn_level[b]     = raw_stable ^ BTN_IDLE_RAW;
        assign btn_pulse[b]     = pulse_q;
        assign btn_repeating[b] = (state == REPEAT);

        always_comb begin
            state_next = state;
            timer_next = timer;
            pulse_next = 1'b0;
            case (state)
                IDLE: begin
                    if (pressed_next && !btn_level[b]) begin
                        pulse_next = 1'b1;
                        timer_next = '0;
                        state_next = HOLD;
                    end
                end
                HOLD: begin
                    if (!pressed_next) begin
                        timer_next = '0;
                        state_next = IDLE;
                    end else if (timer == HOLD_LAST) begin
                        // Without repeat the timer simply parks at its last value.
                        if (REPEAT_EN != 0) begin
                            pulse_next = 1'b1;
                            timer_next = '0;
                            state_next = REPEAT;
                        end
                    end else begin
                        timer_next = timer + TW'(1);
                    end
                end
                REPEAT: begin
                    if (!pressed_next) begin
                        timer_next = '0;
                        state_next = IDLE;
                    end else if (timer == REPEAT_LAST) begin
                        pulse_next = 1'b1;
                        timer_next = '0;
                    end else begin
                        timer_next = timer + TW'(1);
                    end
                end
                default: begin
                    timer_next = '0;
                    state_next = IDLE;
                end
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state   <= IDLE;
                timer   <= '0;
                pulse_q <= 1'b0;
            end else begin
                state   <= state_next;
                timer   <= timer_next;
                pulse_q <= pulse_next;
            end
        end
    end

endmodule
